// File: rtl/serial_subtractor_4bit.sv
// serial_subtractor_4bit
//   Bit-serial 4-bit subtractor: d = a - b - b_in, one bit per clock through a
//   single registered borrow stage. start/done handshake lets control logic
//   time-share the datapath (one operation per 6 cycles).
//
//   Optional feature macro: SERIAL_SUB_OVF_EN (adds the signed-overflow port).
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request pulse, sampled only while idle
//   a      in   [3:0] minuend, sampled with accepted start
//   b      in   [3:0] subtrahend, sampled with accepted start
//   b_in   in   borrow-in, sampled with accepted start
//   busy   out  high whenever an operation is in flight (state != IDLE)
//   done   out  one-cycle pulse, result valid
//   d      out  [3:0] difference mod 16, held until the next result
//   b_out  out  final borrow (a < b + b_in, unsigned)
//   ovf    out  signed overflow (only with SERIAL_SUB_OVF_EN)
module serial_subtractor_4bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       b_in,
  output logic       busy,
  output logic       done,
  output logic [3:0] d,
  output logic       b_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic       ovf
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t     state, state_nx;
  logic [3:0] a_sr, b_sr;
  logic [2:0] res;        // low three result bits collected so far
  logic       borrow;
  logic [1:0] cnt;
  logic       diff, borrow_nx, last;

  always_comb begin
    diff      = a_sr[0] ^ b_sr[0] ^ borrow;
    borrow_nx = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
    last      = (cnt == 2'd3);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      d      <= '0;
      b_out  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sr   <= a;
          b_sr   <= b;
          borrow <= b_in;
          res    <= '0;
          cnt    <= '0;
        end
        SHIFT: begin
          a_sr   <= {1'b0, a_sr[3:1]};
          b_sr   <= {1'b0, b_sr[3:1]};
          res    <= {diff, res[2:1]};
          borrow <= borrow_nx;
          cnt    <= cnt + 2'd1;
          // Outputs only move on the final bit so partial sums never show.
          if (last) begin
            d     <= {diff, res};
            b_out <= borrow_nx;
`ifdef SERIAL_SUB_OVF_EN
            // On the last bit a_sr[0]/b_sr[0] are the operand sign bits and
            // diff is the result sign bit, so no extra sign flops are needed.
            ovf   <= (a_sr[0] ^ b_sr[0]) & (diff ^ a_sr[0]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Directed-vector bench for serial_subtractor_4bit.
module tb_serial_subtractor_4bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] a, b;
  logic       b_in;
  logic       busy, done, b_out;
  logic [3:0] d;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int nvec = 0;
  int nerr = 0;
  logic [3:0] prev_d;
  logic       prev_bo;

  always #5 clk = ~clk;

  serial_subtractor_4bit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .b_in(b_in),
    .busy(busy), .done(done), .d(d), .b_out(b_out)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Accept at edge N, check every cycle through return to idle.
  // repulse drives a second start (different operands) before edge N+2.
  task automatic op(input logic [3:0] ia, input logic [3:0] ib, input logic ibin,
                    input logic [3:0] ed, input logic eb, input logic eo,
                    input bit repulse);
    @(negedge clk);
    a = ia; b = ib; b_in = ibin; start = 1'b1;
    @(negedge clk);                       // after edge N
    start = 1'b0; a = ~ia; b = ~ib; b_in = ~ibin;
    chk("busy_acc", busy, 1);
    chk("done_acc", done, 0);
    for (int k = 1; k <= 3; k++) begin
      if (repulse && k == 1) begin start = 1'b1; a = 4'h1; b = 4'h2; b_in = 1'b0; end
      @(negedge clk);                     // after edge N+k
      start = 1'b0;
      chk("busy_sh", busy, 1);
      chk("done_sh", done, 0);
      chk("d_hold", d, prev_d);
      chk("bo_hold", b_out, prev_bo);
    end
    @(negedge clk);                       // after edge N+4
    chk("done", done, 1);
    chk("busy_dn", busy, 1);
    chk("d", d, ed);
    chk("b_out", b_out, eb);
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf", ovf, eo);
`else
    if (eo === 1'bx) chk("eo_unused", eo, 0);
`endif
    @(negedge clk);                       // after edge N+5
    chk("done_off", done, 0);
    chk("busy_off", busy, 0);
    chk("d_keep", d, ed);
    prev_d = ed; prev_bo = eb;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = 4'h0; b = 4'h0; b_in = 1'b0;
    prev_d = 4'h0; prev_bo = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_d", d, 0);
    chk("rst_bo", b_out, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    //   a     b    bin  d     bo    ovf
    op(4'h9, 4'h3, 1'b0, 4'h6, 1'b0, 1'b1, 0);
    op(4'h3, 4'h9, 1'b0, 4'hA, 1'b1, 1'b1, 0);
    op(4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 0);
    op(4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1, 0);
    op(4'h7, 4'hF, 1'b0, 4'h8, 1'b1, 1'b1, 0);
    op(4'h2, 4'h2, 1'b1, 4'hF, 1'b1, 1'b0, 0);
    op(4'h5, 4'h2, 1'b0, 4'h3, 1'b0, 1'b0, 0);
    // second start mid-operation is ignored
    op(4'hC, 4'h5, 1'b1, 4'h6, 1'b0, 1'b1, 1);
    chk("no_queue", busy, 0);

    // reset during SHIFT aborts, clears outputs, no done
    @(negedge clk);
    a = 4'h9; b = 4'h3; b_in = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);       // after edge N+2
    #2 rst_n = 1'b0;
    #1;
    chk("abort_d", d, 0);
    chk("abort_bo", b_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_nodone", done, 0);
    end
    prev_d = 4'h0; prev_bo = 1'b0;
    op(4'hA, 4'h4, 1'b0, 4'h6, 1'b0, 1'b1, 0);

    // start held high: accepted every 6 cycles
    @(negedge clk);
    a = 4'hF; b = 4'hF; b_in = 1'b0; start = 1'b1;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);                     // after edge e (accept at edge 0)
      chk("held_done", done, (e % 6 == 4) ? 8'd1 : 8'd0);
      if (e % 6 == 4) begin
        chk("held_d", d, 0);
        chk("held_bo", b_out, 0);
      end
    end
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("held_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
